// File: rtl/sar_controller_10b_signed_pkg.sv
// Shared definitions for the signed SAR controller: FSM states and default sizing.
package sar_controller_10b_signed_pkg;

  localparam int N_BITS_DEF      = 10;
  localparam int DW_DEF          = 12;
  localparam int TIMEOUT_CYC_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRIAL = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } sar_state_e;

endpackage

// File: rtl/sar_controller_10b_signed_wait_timer.sv
// Wait-cycle counter for one comparator request; saturates and flags expiry at TIMEOUT_CYC.
module sar_wait_timer #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/sar_controller_10b_signed.sv
// Successive-approximation controller: MSB-first binary search over the signed range,
// one comparator request per bit, with a per-bit wait timeout.
module sar_controller_10b_signed
  import sar_controller_10b_signed_pkg::*;
#(
  parameter int N_BITS      = N_BITS_DEF,
  parameter int DW          = DW_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              comp_result,
  input  logic              comp_done,
  output logic              comp_req,
  output logic [DW-1:0]     dac_code,
  output logic              busy,
  output logic              data_valid,
  output logic [N_BITS-1:0] data_out,
  output logic              timeout_err
);

  localparam int KW = $clog2(N_BITS);

  sar_state_e        state, state_nxt;
  logic [N_BITS-1:0] code, bit_mask, trial, trial_tc, code_upd;
  logic [KW-1:0]     k;
  logic              timer_expired, timer_en;
  logic              accept, resolve, resolve_bit, resolve_to;

  // The search runs in offset-binary; flipping the MSB converts to two's complement.
  assign bit_mask = {{(N_BITS-1){1'b0}}, 1'b1} << k;
  assign trial    = code | bit_mask;
  assign trial_tc = {~trial[N_BITS-1], trial[N_BITS-2:0]};
  assign code_upd = resolve_bit ? (code | bit_mask) : (code & ~bit_mask);

  sar_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ST_TRIAL),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // comp_done takes priority over an expiry on the same edge.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    resolve     = 1'b0;
    resolve_bit = 1'b0;
    resolve_to  = 1'b0;
    timer_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_TRIAL;
        end
      end
      ST_TRIAL: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (comp_done) begin
          resolve     = 1'b1;
          resolve_bit = comp_result;
        end else if (timer_expired) begin
          resolve    = 1'b1;
          resolve_to = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
        if (resolve) begin
          state_nxt = (k == '0) ? ST_DONE : ST_TRIAL;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code        <= '0;
      k           <= '0;
      comp_req    <= 1'b0;
      dac_code    <= '0;
      busy        <= 1'b0;
      data_valid  <= 1'b0;
      data_out    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (accept) begin
        code        <= '0;
        k           <= KW'(N_BITS - 1);
        timeout_err <= 1'b0;
        busy        <= 1'b1;
      end
      if (state == ST_TRIAL) begin
        dac_code <= {{(DW-N_BITS){trial_tc[N_BITS-1]}}, trial_tc};
        comp_req <= 1'b1;
      end
      if (resolve) begin
        code     <= code_upd;
        comp_req <= 1'b0;
        if (resolve_to) begin
          timeout_err <= 1'b1;
        end
        if (k == '0) begin
          data_valid <= 1'b1;
          busy       <= 1'b0;
          data_out   <= {~code_upd[N_BITS-1], code_upd[N_BITS-2:0]};
        end else begin
          k <= k - KW'(1);
        end
      end
      if (state == ST_DONE) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sar_controller_10b_signed.sv
// Self-checking bench: comparator model plus floor-search reference for the signed SAR controller.
module tb_sar_controller_10b_signed;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        comp_result = 1'b0;
  logic        model_done = 1'b0;
  logic        poke_done = 1'b0;
  logic        comp_done;
  logic        comp_req;
  logic [11:0] dac_code;
  logic        busy;
  logic        data_valid;
  logic [9:0]  data_out;
  logic        timeout_err;

  logic signed [11:0] vip = '0;
  int  w_fixed = 0;
  bit  w_random = 1'b0;
  int  silent_k = -1;
  int  conv_id = 0;
  int  lat_sum = 0;
  int  cur_k = -1;
  int  checks = 0;
  int  failures = 0;

  assign comp_done = model_done | poke_done;

  sar_controller_10b_signed dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .comp_result (comp_result),
    .comp_done   (comp_done),
    .comp_req    (comp_req),
    .dac_code    (dac_code),
    .busy        (busy),
    .data_valid  (data_valid),
    .data_out    (data_out),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Floor of vip onto the signed 10b grid; a silent bit is searched explicitly with that bit forced low.
  function automatic int ref_code(input int v, input int sk);
    int lo;
    if (sk < 0) begin
      return (v > 511) ? 511 : ((v < -512) ? -512 : v);
    end
    lo = -512;
    for (int b = 9; b >= 0; b--) begin
      if (b != sk && v >= lo + (1 << b)) lo += (1 << b);
    end
    return lo;
  endfunction

  // Comparator: answers each request after W cycles, or stays silent on the chosen bit.
  initial begin
    int  idx, lo, seen, kb, w, t;
    bit  req_q;
    idx = 0; lo = -512; seen = -1; req_q = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (comp_req && !req_q) begin
        if (seen != conv_id) begin
          seen = conv_id; idx = 0; lo = -512; lat_sum = 1;
        end
        kb = 9 - idx;
        idx++;
        cur_k = kb;
        if (kb < 0) begin
          check_output("trial_count", idx, 10);
        end else begin
          t = lo + (1 << kb);
          check_output("dac_trial", int'($signed(dac_code)), t);
          if (kb != silent_k) begin
            w = w_random ? int'($urandom_range(0, 5)) : w_fixed;
            lat_sum += 2 + w;
            repeat (w) begin @(posedge clk); #1; end
            comp_result = ($signed(vip) >= $signed(dac_code));
            if (int'(vip) >= t) lo = t;
            model_done = 1'b1;
            @(posedge clk); #1;
            model_done = 1'b0;
          end
        end
      end
      req_q = comp_req;
    end
  end

  task automatic apply_stimulus(input int v, input int wf, input bit wr, input int sk,
                                input bit repulse, input int exp_to);
    int cyc;
    bit got;
    vip = 12'(v); w_fixed = wf; w_random = wr; silent_k = sk;
    conv_id++;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (repulse && cyc == 7) start = 1'b1;
      if (repulse && cyc == 8) start = 1'b0;
      if (cyc == 1) check_output("timeout_cleared", int'(timeout_err), 0);
      if (data_valid) begin
        got = 1'b1;
        check_output("data_out", int'($signed(data_out)), ref_code(v, sk));
        check_output("timeout_err", int'(timeout_err), exp_to);
        check_output("busy_at_valid", int'(busy), 0);
        check_output("req_at_valid", int'(comp_req), 0);
        if (sk < 0) check_output("latency", cyc, lat_sum);
      end else begin
        check_output("busy_during", int'(busy), 1);
      end
    end
    if (!got) check_output("valid_wait_expired", 0, 1);
    if (repulse && got) begin
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      check_output("valid_one_cycle", int'(data_valid), 0);
      repeat (30) begin
        @(negedge clk);
        check_output("ignored_start_valid", int'(data_valid), 0);
        check_output("ignored_start_busy", int'(busy), 0);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_comp_req"}, int'(comp_req), 0);
    check_output({tag, "_busy"}, int'(busy), 0);
    check_output({tag, "_data_valid"}, int'(data_valid), 0);
    check_output({tag, "_timeout_err"}, int'(timeout_err), 0);
    check_output({tag, "_dac_code"}, int'(dac_code), 0);
    check_output({tag, "_data_out"}, int'(data_out), 0);
  endtask

  initial begin
    int  n;
    #2;
    check_reset_outputs("reset");
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    check_output("model_700", ref_code(700, -1), 511);
    check_output("model_m600", ref_code(-600, -1), -512);
    check_output("model_silent5", ref_code(511, 5), 479);
    check_output("model_37", ref_code(37, -1), 37);

    apply_stimulus(0, 0, 1'b0, -1, 1'b0, 0);
    check_output("lit_latency_w0", lat_sum, 21);

    apply_stimulus(-512, 2, 1'b0, -1, 1'b0, 0);
    apply_stimulus(511, 2, 1'b0, -1, 1'b0, 0);
    apply_stimulus(700, 2, 1'b0, -1, 1'b0, 0);
    apply_stimulus(-600, 2, 1'b0, -1, 1'b0, 0);
    check_output("lit_latency_w2", lat_sum, 41);

    apply_stimulus(-1, 0, 1'b1, -1, 1'b0, 0);
    apply_stimulus(37, 0, 1'b1, -1, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(int'($urandom_range(0, 1600)) - 800, 0, 1'b1, -1, 1'b0, 0);
    end

    apply_stimulus(511, 1, 1'b0, 5, 1'b0, 1);
    apply_stimulus(3, 0, 1'b0, -1, 1'b0, 0);

    apply_stimulus(-77, 1, 1'b0, -1, 1'b1, 0);
    @(negedge clk); poke_done = 1'b1;
    @(negedge clk); poke_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_output("poke_busy", int'(busy), 0);
      check_output("poke_req", int'(comp_req), 0);
      check_output("poke_valid", int'(data_valid), 0);
      check_output("poke_data_out", int'($signed(data_out)), -77);
    end

    vip = 12'(200); w_fixed = 3; w_random = 1'b0; silent_k = -1;
    conv_id++;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (!(cur_k == 3 && comp_req) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check_output("bit3_wait_expired", 0, 1);
    @(posedge clk); #3; rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check_output("abort_no_valid", int'(data_valid), 0);
    end
    apply_stimulus(100, 0, 1'b0, -1, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
